seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16; the number of consecutive unchanged cycles of {sel,seg} required before a digit is sampled (legal range 2..65535).
REQ-002 SHALL have parameter FRAME_TIMEOUT, default 250000; the maximum number of cycles allowed from the first digit capture of a frame to frame completion.
REQ-003 sys_clk  input  1  single clock for all logic; rising edge.
REQ-004 sys_rst_p  input  1  reset; synchronous, active-high.
REQ-005 sel  input  4  digit select from the 4-digit scan display, active-low; sel[3] selects the most significant digit, sel[0] the least.
REQ-006 seg  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 data  output  16  last complete decoded frame; nibble n = digit selected by sel[n].
REQ-008 data_valid  output  1  one-cycle pulse when data updates.
REQ-009 frame_err  output  1  registered with data; 1 = at least one digit in that frame had an undecodable pattern.
REQ-010 timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-011 Inputs SHALL be registered once (sel_q, seg_q); all decisions use the registered values; the prior-cycle copy is held for change detection.
REQ-012 Stability counter (16 bit) SHALL clear to 0 on any change of {sel_q,seg_q}, otherwise increment, saturating at SETTLE_CYCLES-1.
REQ-013 FSM states SHALL be WAIT_STABLE and HELD; reset state WAIT_STABLE.
REQ-014 WAIT_STABLE -> HELD when the counter equals SETTLE_CYCLES-1 and sel_q has exactly one bit low; exactly one capture occurs on that transition.
REQ-015 HELD -> WAIT_STABLE on any change of {sel_q,seg_q}; no further capture while in HELD.
REQ-016 sel_q values with zero or more than one bit low SHALL never capture; the FSM stays in (or returns to) WAIT_STABLE.
REQ-017 Decode SHALL map active-low seg to a nibble: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F.
REQ-018 Any other seg pattern (including blank 0x7F) SHALL store nibble 0 and set the frame's sticky error bit.
REQ-019 Each capture SHALL write the shadow nibble for the selected digit and set its bit in a 4-bit capture mask; capturing a digit already in the mask overwrites it.
REQ-020 When the mask becomes 4'b1111, on the next cycle: data <= shadow, frame_err <= sticky error, data_valid = 1 for one cycle, mask and sticky error cleared.
REQ-021 A timeout counter (18 bit) SHALL run while the mask is nonzero and incomplete; on reaching FRAME_TIMEOUT-1: mask and sticky error cleared, timeout = 1 for one cycle, data unchanged.
REQ-022 When completion and timeout coincide in the same cycle, completion SHALL win; no timeout pulse.
REQ-023 Latency SHALL be: last input change to data_valid = 1 (input reg) + SETTLE_CYCLES + 1 cycles, fixed.

Reset
REQ-024 While sys_rst_p = 1 at a rising edge: data = 0x0000, data_valid = 0, frame_err = 0, timeout = 0, mask = 0, sticky error = 0, counters = 0, FSM = WAIT_STABLE, input regs = sel 4'hF / seg 7'h7F.
REQ-025 Reset mid-frame SHALL discard all partial captures; no data_valid or timeout pulse in or immediately after reset.

Verification
REQ-026 Scan 1,2,3,4 (sel 0111/1011/1101/1110, 1000 cycles per digit, seg 0x79/0x24/0x30/0x19) -> data = 0x1234, frame_err = 0, one data_valid pulse per frame.
REQ-027 Glitch: seg changes for SETTLE_CYCLES-2 cycles mid-digit then restores -> no capture from the glitch value; frame still decodes correctly.
REQ-028 Digit 2 driven with seg = 0x7F in a 0xA5C3 scan -> data = 0xA0C3, frame_err = 1.
REQ-029 Only digits 3 and 2 scanned, then sel = 4'hF held -> timeout pulse FRAME_TIMEOUT cycles after the first capture; data keeps its previous value.
REQ-030 sel = 4'b0011 held stable 1000 cycles -> no capture, mask stays 0.
REQ-031 sys_rst_p asserted after 3 digits captured, then a full scan of 0xBEEF -> data = 0xBEEF, exactly one data_valid pulse.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Recovers the 4-digit value shown on a multiplexed, active-low 7-segment scan display
// by sampling each digit only after its select and segment lines have been stable.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned FRAME_TIMEOUT = 250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_p,
  input  logic [3:0]  sel,
  input  logic [6:0]  seg,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        timeout
);

  typedef enum logic {
    WAIT_STABLE = 1'b0,
    HELD        = 1'b1
  } state_t;

  localparam logic [15:0] SETTLE_MAX  = 16'(SETTLE_CYCLES - 1);
  localparam logic [17:0] TIMEOUT_MAX = 18'(FRAME_TIMEOUT - 1);

  // Returns {undecodable, nibble}; unknown patterns (blank included) decode as 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  state_t      state;
  logic [3:0]  sel_q;
  logic [6:0]  seg_q;
  logic [3:0]  sel_prev;
  logic [6:0]  seg_prev;
  logic [15:0] stable_cnt;
  logic [17:0] frame_cnt;
  logic [3:0]  mask;
  logic [15:0] shadow;
  logic        sticky_err;

  logic        change;
  logic        one_low;
  logic [15:0] stable_next;
  logic        capture;
  logic [4:0]  decoded;
  logic [3:0]  cap_bit;
  logic [3:0]  mask_merged;
  logic [15:0] shadow_next;
  logic        frame_done;
  logic        frame_open;
  logic        timeout_hit;

  assign change  = {sel_q, seg_q} != {sel_prev, seg_prev};
  assign one_low = $countones(~sel_q) == 1;
  assign decoded = decode_seg(seg_q);

  // The capture fires on the edge where the counter reaches its settle value,
  // so a digit is sampled after exactly SETTLE_CYCLES unchanged cycles.
  assign capture = (state == WAIT_STABLE) && !change && one_low &&
                   (stable_next == SETTLE_MAX);

  assign cap_bit     = capture ? ~sel_q : 4'h0;
  assign mask_merged = mask | cap_bit;
  assign frame_done  = (mask == 4'hF);
  assign frame_open  = (mask != 4'h0) && !frame_done;
  // A last-digit capture landing on the timeout cycle completes the frame instead.
  assign timeout_hit = frame_open && (frame_cnt == TIMEOUT_MAX) && (mask_merged != 4'hF);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stable_next = stable_cnt;
    if (change) begin
      stable_next = 16'd0;
    end else if (stable_cnt != SETTLE_MAX) begin
      stable_next = stable_cnt + 16'd1;
    end
  end

  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < 4; i++) begin
      if (cap_bit[i]) begin
        shadow_next[i*4 +: 4] = decoded[3:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      state      <= WAIT_STABLE;
      sel_q      <= 4'hF;
      seg_q      <= 7'h7F;
      sel_prev   <= 4'hF;
      seg_prev   <= 7'h7F;
      stable_cnt <= 16'd0;
      frame_cnt  <= 18'd0;
      mask       <= 4'h0;
      shadow     <= 16'h0000;
      sticky_err <= 1'b0;
      data       <= 16'h0000;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      sel_q      <= sel;
      seg_q      <= seg;
      sel_prev   <= sel_q;
      seg_prev   <= seg_q;
      stable_cnt <= stable_next;
      shadow     <= shadow_next;
      data_valid <= 1'b0;
      timeout    <= 1'b0;

      case (state)
        WAIT_STABLE: if (capture) state <= HELD;
        HELD:        if (change)  state <= WAIT_STABLE;
        default:     state <= WAIT_STABLE;
      endcase

      if (frame_done) begin
        data       <= shadow;
        frame_err  <= sticky_err;
        data_valid <= 1'b1;
        mask       <= cap_bit;
        sticky_err <= capture & decoded[4];
        frame_cnt  <= 18'd0;
      end else if (timeout_hit) begin
        mask       <= 4'h0;
        sticky_err <= 1'b0;
        frame_cnt  <= 18'd0;
        timeout    <= 1'b1;
      end else begin
        mask       <= mask_merged;
        sticky_err <= sticky_err | (capture & decoded[4]);
        frame_cnt  <= frame_open ? frame_cnt + 18'd1 : 18'd0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: decode, glitch rejection, bad patterns,
// timeout, illegal selects, latency and mid-frame reset.
module tb_seg_scan_decoder;

  localparam int S  = 16;
  localparam int FT = 5000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_p = 1'b1;
  logic [3:0]  sel = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_count = 0;
  int to_count = 0;
  int to_cyc = -1;

  seg_scan_decoder #(
    .SETTLE_CYCLES(S),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_p (sys_rst_p),
    .sel       (sel),
    .seg       (seg),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  // Pulse monitors: counting high cycles also catches pulses wider than one cycle.
  always @(negedge sys_clk) begin
    if (data_valid === 1'b1) dv_count++;
    if (timeout === 1'b1) begin
      to_count++;
      to_cyc = cyc;
    end
  end

  task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic scan4(input logic [6:0] g3, input logic [6:0] g2,
                       input logic [6:0] g1, input logic [6:0] g0, input int n);
    drive(4'b0111, g3, n);
    drive(4'b1011, g2, n);
    drive(4'b1101, g1, n);
    drive(4'b1110, g0, n);
  endtask

  task automatic do_reset(input int n);
    sel = 4'hF;
    seg = 7'h7F;
    sys_rst_p = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1;
    sys_rst_p = 1'b0;
  endtask

  task automatic test_reset;
    int dv0, to0;
    sel = 4'hF;
    seg = 7'h7F;
    sys_rst_p = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    dv0 = dv_count;
    to0 = to_count;
    sys_rst_p = 1'b0;
    idle(40);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL reset_idle_dv: got %0d pulses expected 0", dv_count - dv0); end
    checks++; if (to_count - to0 !== 0) begin errors++; $display("FAIL reset_idle_to: got %0d pulses expected 0", to_count - to0); end
  endtask

  task automatic test_scan_1234;
    int dv0, to0;
    do_reset(2);
    dv0 = dv_count;
    to0 = to_count;
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 1000);
    idle(30);
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL scan1_data: got %h expected 1234", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL scan1_err: got %b expected 0", frame_err); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL scan1_dv: got %0d pulses expected 1", dv_count - dv0); end
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 1000);
    idle(30);
    checks++; if (dv_count - dv0 !== 2) begin errors++; $display("FAIL scan2_dv: got %0d pulses expected 2", dv_count - dv0); end
    checks++; if (to_count - to0 !== 0) begin errors++; $display("FAIL scan_to: got %0d pulses expected 0", to_count - to0); end
  endtask

  task automatic test_latency;
    do_reset(2);
    drive(4'b0111, 7'h79, 100);
    drive(4'b1011, 7'h24, 100);
    drive(4'b1101, 7'h30, 100);
    sel = 4'b1110;
    seg = 7'h19;
    for (int k = 1; k <= S + 3; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == S + 1) begin
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0 at edge %0d", data_valid, k); end
      end
      if (k == S + 2) begin
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL lat_pulse: got %b expected 1 at edge %0d", data_valid, k); end
        checks++; if (data !== 16'h1234) begin errors++; $display("FAIL lat_data: got %h expected 1234", data); end
      end
      if (k == S + 3) begin
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL lat_width: got %b expected 0 at edge %0d", data_valid, k); end
      end
    end
    idle(20);
  endtask

  task automatic test_glitch;
    int dv0;
    do_reset(2);
    dv0 = dv_count;
    drive(4'b0111, 7'h79, 100);
    drive(4'b1011, 7'h24, 50);
    drive(4'b1011, 7'h7F, S - 2);
    drive(4'b1011, 7'h24, 50);
    drive(4'b1101, 7'h30, 100);
    drive(4'b1110, 7'h19, 5);
    drive(4'b1110, 7'h40, S - 2);
    drive(4'b1110, 7'h19, 100);
    idle(30);
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL glitch_data: got %h expected 1234", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b expected 0", frame_err); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL glitch_dv: got %0d pulses expected 1", dv_count - dv0); end
  endtask

  task automatic test_bad_segment;
    int dv0;
    do_reset(2);
    dv0 = dv_count;
    scan4(7'h08, 7'h7F, 7'h46, 7'h30, 100);
    idle(30);
    checks++; if (data !== 16'hA0C3) begin errors++; $display("FAIL bad_data: got %h expected a0c3", data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", frame_err); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL bad_dv: got %0d pulses expected 1", dv_count - dv0); end
    scan4(7'h08, 7'h12, 7'h46, 7'h30, 100);
    idle(30);
    checks++; if (data !== 16'hA5C3) begin errors++; $display("FAIL clean_data: got %h expected a5c3", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clean_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_timeout;
    int dv0, to0, c0;
    do_reset(2);
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 100);
    idle(30);
    dv0 = dv_count;
    to0 = to_count;
    c0 = cyc;
    drive(4'b0111, 7'h03, 100);
    drive(4'b1011, 7'h06, 100);
    idle(FT + S + 1 - 200 + 20);
    checks++; if (to_count - to0 !== 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", to_count - to0); end
    checks++; if (to_cyc !== c0 + S + 1 + FT) begin errors++; $display("FAIL to_time: got cycle %0d expected %0d", to_cyc, c0 + S + 1 + FT); end
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL to_data: got %h expected 1234", data); end
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL to_dv: got %0d pulses expected 0", dv_count - dv0); end
    drive(4'b1101, 7'h30, 100);
    drive(4'b1110, 7'h19, 100);
    idle(50);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL to_cleared: got %0d pulses expected 0", dv_count - dv0); end
  endtask

  task automatic test_invalid_sel;
    int dv0, to0;
    do_reset(2);
    dv0 = dv_count;
    to0 = to_count;
    drive(4'b0011, 7'h79, 1000);
    drive(4'b0000, 7'h24, 200);
    drive(4'b1101, 7'h30, 100);
    drive(4'b1110, 7'h19, 100);
    idle(50);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL inv_dv: got %0d pulses expected 0", dv_count - dv0); end
    checks++; if (to_count - to0 !== 0) begin errors++; $display("FAIL inv_to: got %0d pulses expected 0", to_count - to0); end
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL inv_data: got %h expected 0000", data); end
  endtask

  task automatic test_reset_mid_frame;
    int dv0, to0;
    do_reset(2);
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 100);
    idle(30);
    drive(4'b0111, 7'h12, 100);
    drive(4'b1011, 7'h02, 100);
    drive(4'b1101, 7'h78, 100);
    dv0 = dv_count;
    to0 = to_count;
    do_reset(2);
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL mid_rst_data: got %h expected 0000", data); end
    idle(20);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL mid_rst_dv: got %0d pulses expected 0", dv_count - dv0); end
    checks++; if (to_count - to0 !== 0) begin errors++; $display("FAIL mid_rst_to: got %0d pulses expected 0", to_count - to0); end
    scan4(7'h03, 7'h06, 7'h06, 7'h0E, 100);
    idle(30);
    checks++; if (data !== 16'hBEEF) begin errors++; $display("FAIL beef_data: got %h expected beef", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL beef_err: got %b expected 0", frame_err); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL beef_dv: got %0d pulses expected 1", dv_count - dv0); end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_latency();
    test_glitch();
    test_bad_segment();
    test_timeout();
    test_invalid_sel();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
